seg7_scan_ctrl: RTL and testbench
=================================

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, giving clk cycles per digit slot (legal range 2 to 2^20).
REQ-002 SHALL have parameter LEAD_BLANK, default 1, where 1 enables leading-zero blanking.
REQ-003 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port bin  in  10  unsigned binary value to convert.
REQ-006 SHALL have port bin_valid  in  1  request; bin is sampled when bin_valid=1 and busy=0.
REQ-007 SHALL have port busy  out  1  high whenever the FSM is not IDLE.
REQ-008 SHALL have port done  out  1  one-cycle pulse when a new bcd value is latched.
REQ-009 SHALL have port ovf  out  1  high when the last accepted bin exceeded 999.
REQ-010 SHALL have port bcd  out  12  latched BCD result: [11:8] hundreds, [7:4] tens, [3:0] ones.
REQ-011 SHALL have port seg  out  7  active-high segments, bit6=a through bit0=g.
REQ-012 SHALL have port dig_en  out  3  one-hot active-high digit select: 001 ones, 010 tens, 100 hundreds.

Function
REQ-013 FSM SHALL have states IDLE, CONV and DONE.
REQ-014 IDLE SHALL move to CONV when bin_valid=1; this is the accept edge, at which bin is loaded into the shift register and the iteration count is cleared.
REQ-015 CONV SHALL run exactly 10 cycles, one bit per cycle, MSB first.
REQ-016 Each CONV cycle SHALL first add 3 to every working BCD nibble >= 5, then shift the 12-bit BCD and binary registers left by one bit.
REQ-017 After the 10th CONV cycle the FSM SHALL enter DONE for exactly one cycle, then return to IDLE.
REQ-018 In DONE, bcd SHALL be updated and done SHALL be 1.
REQ-019 Latency SHALL be fixed: accept at edge T, then bcd valid and done high in the cycle following edge T+11; busy is high from T+1 through the DONE cycle.
REQ-020 bin_valid while busy=1 SHALL be ignored; no queuing.
REQ-021 bin_valid during the DONE cycle SHALL be ignored.
REQ-022 If the accepted bin > 999, bcd SHALL be 12'h999 and ovf=1 at DONE; otherwise ovf=0.
REQ-023 A digit scan counter SHALL count 0..SCAN_DIV-1 and wrap.
REQ-024 On the wrap, the digit index SHALL advance ones->tens->hundreds->ones.
REQ-025 The scan SHALL run continuously and independently of the FSM.
REQ-026 seg SHALL be the decode of the bcd nibble selected by dig_en.
REQ-027 Digit decode SHALL be: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
REQ-028 Nibble values 10-15 SHALL decode to blank, 0000000.
REQ-029 With LEAD_BLANK=1, hundreds SHALL be blanked when zero, and tens blanked when both hundreds and tens are zero.
REQ-030 The ones digit SHALL never be blanked.
REQ-031 seg and dig_en SHALL be registered, changing on the same edge so that no mixed digit/segment cycle occurs.
REQ-032 The display SHALL use only latched bcd; the working registers SHALL never reach seg.

Reset
REQ-033 rst=1 SHALL force: FSM to IDLE, bcd=0, ovf=0, done=0, busy=0, scan counter=0, dig_en=001, seg=1111110.
REQ-034 rst asserted during CONV SHALL abort the conversion with no done pulse.
REQ-035 rst SHALL override a simultaneous bin_valid.

Structure
REQ-036 Package seg7_pkg SHALL hold the FSM state enum, the ten segment constants, SEG_BLANK and the conversion width constants (10 and 12).
REQ-037 Sub-module seg7_decode SHALL be combinational, mapping a 4-bit nibble plus a blank input to 7-bit seg.

Verification
REQ-038 Test: reset then idle, SCAN_DIV=4 -> dig_en cycles 001,010,100 every 4 clk; seg shows 1111110 on ones and 0000000 on tens and hundreds.
REQ-039 Test: bin=10'd255 pulsed -> done exactly 11 cycles after accept; bcd=12'h255, ovf=0.
REQ-040 Test: bin=10'd1023 -> bcd=12'h999, ovf=1, seg=1111011 on all three digits.
REQ-041 Test: bin=10'd7, LEAD_BLANK=1 -> hundreds and tens blank, ones 1110000; with LEAD_BLANK=0 -> 1111110, 1111110, 1110000.
REQ-042 Test: second bin_valid (bin=500) during CONV of 123 -> ignored; bcd=12'h123; one done pulse only.
REQ-043 Test: rst pulsed at the 5th CONV cycle of bin=999 -> no done; bcd=0; the next request (bin=42) yields 12'h042.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the binary-to-BCD converter and the 7-segment scanner.
// Segment patterns are active-high, with bit6 = a down to bit0 = g.
package seg7_pkg;

    localparam int BIN_W = 10;
    localparam int BCD_W = 12;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to 7-segment decoder.
// Non-decimal nibbles and a forced blank both produce a dark digit.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (nibble)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Sequential double-dabble converter (10-bit binary to 3-digit BCD) feeding a
// free-running multiplexed 7-segment scanner that only ever shows the latched result.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int LEAD_BLANK = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] bin,
    input  logic             bin_valid,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [BCD_W-1:0] bcd,
    output logic [6:0]       seg,
    output logic [2:0]       dig_en
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    state_t           state;
    logic [BIN_W-1:0] bin_sh;
    logic [BCD_W-1:0] bcd_work;
    logic [BCD_W-1:0] bcd_adj;
    logic [3:0]       iter;
    logic             ovf_pend;

    logic [CNT_W-1:0] scan_cnt;
    logic             scan_wrap;
    logic [2:0]       next_dig;
    logic [3:0]       sel_nibble;
    logic             sel_blank;
    logic [6:0]       seg_next;

    // Every nibble of 5 or more gets +3 so the following left shift carries correctly into the next digit.
    always_comb begin
        bcd_adj = bcd_work;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (bcd_work[i*4 +: 4] >= 4'd5)
                bcd_adj[i*4 +: 4] = bcd_work[i*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            bcd      <= '0;
            bin_sh   <= '0;
            bcd_work <= '0;
            iter     <= '0;
            ovf_pend <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bin_valid) begin
                        state    <= CONV;
                        busy     <= 1'b1;
                        bin_sh   <= bin;
                        bcd_work <= '0;
                        iter     <= '0;
                        ovf_pend <= (bin > 10'd999);
                    end
                end
                CONV: begin
                    bcd_work <= {bcd_adj[BCD_W-2:0], bin_sh[BIN_W-1]};
                    bin_sh   <= {bin_sh[BIN_W-2:0], 1'b0};
                    if (iter == 4'd9)
                        state <= DONE;
                    else
                        iter <= iter + 4'd1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    bcd   <= ovf_pend ? 12'h999 : bcd_work;
                    ovf   <= ovf_pend;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign scan_wrap = (scan_cnt == CNT_MAX);
    assign next_dig  = scan_wrap ? {dig_en[1:0], dig_en[2]} : dig_en;

    // Segments are decoded for the digit that will be enabled next, so both registers move together.
    always_comb begin
        sel_nibble = bcd[3:0];
        sel_blank  = 1'b0;
        case (next_dig)
            3'b010: begin
                sel_nibble = bcd[7:4];
                sel_blank  = (LEAD_BLANK != 0) && (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
            end
            3'b100: begin
                sel_nibble = bcd[11:8];
                sel_blank  = (LEAD_BLANK != 0) && (bcd[11:8] == 4'd0);
            end
            default: begin
                sel_nibble = bcd[3:0];
                sel_blank  = 1'b0;
            end
        endcase
    end

    seg7_decode u_decode (
        .nibble (sel_nibble),
        .blank  (sel_blank),
        .seg    (seg_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            dig_en   <= 3'b001;
            seg      <= SEG_0;
        end else begin
            scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
            dig_en   <= next_dig;
            seg      <= seg_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed self-checking bench for seg7_scan_ctrl with a fast scan (SCAN_DIV=4);
// a second instance with leading-zero blanking disabled shares the same stimulus.
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  bin = '0;
    logic        bin_valid = 1'b0;
    logic        busy, done, ovf;
    logic [11:0] bcd;
    logic [6:0]  seg;
    logic [2:0]  dig_en;
    logic        busy_nb, done_nb, ovf_nb;
    logic [11:0] bcd_nb;
    logic [6:0]  seg_nb;
    logic [2:0]  dig_en_nb;

    int checks = 0;
    int errors = 0;

    seg7_scan_ctrl #(.SCAN_DIV(4), .LEAD_BLANK(1)) dut (
        .clk(clk), .rst(rst), .bin(bin), .bin_valid(bin_valid),
        .busy(busy), .done(done), .ovf(ovf), .bcd(bcd), .seg(seg), .dig_en(dig_en)
    );

    seg7_scan_ctrl #(.SCAN_DIV(4), .LEAD_BLANK(0)) dut_nb (
        .clk(clk), .rst(rst), .bin(bin), .bin_valid(bin_valid),
        .busy(busy_nb), .done(done_nb), .ovf(ovf_nb), .bcd(bcd_nb), .seg(seg_nb), .dig_en(dig_en_nb)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit before driving or sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_dig(input logic [2:0] d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (dig_en === d) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks += 6;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf); end
        if (bcd !== 12'h000) begin errors++; $display("[TB] FAIL reset_bcd: got %h expected 000", bcd); end
        if (dig_en !== 3'b001) begin errors++; $display("[TB] FAIL reset_dig_en: got %b expected 001", dig_en); end
        if (seg !== 7'b1111110) begin errors++; $display("[TB] FAIL reset_seg: got %b expected 1111110", seg); end
    endtask

    task automatic test_scan();
        logic [2:0] exp_dig;
        logic [6:0] exp_seg;
        for (int k = 1; k <= 12; k++) begin
            step();
            case ((k / 4) % 3)
                0:       begin exp_dig = 3'b001; exp_seg = 7'b1111110; end
                1:       begin exp_dig = 3'b010; exp_seg = 7'b0000000; end
                default: begin exp_dig = 3'b100; exp_seg = 7'b0000000; end
            endcase
            checks += 2;
            if (dig_en !== exp_dig) begin errors++; $display("[TB] FAIL scan_dig_en k=%0d: got %b expected %b", k, dig_en, exp_dig); end
            if (seg !== exp_seg) begin errors++; $display("[TB] FAIL scan_seg k=%0d: got %b expected %b", k, seg, exp_seg); end
        end
    endtask

    task automatic test_latency_255();
        bit ok;
        bin = 10'd255;
        bin_valid = 1'b1;
        step();
        bin_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL lat_busy_after_accept: got %b expected 1", busy); end
        for (int i = 1; i <= 11; i++) begin
            step();
            if (i < 11) begin
                checks += 2;
                if (done !== 1'b0) begin errors++; $display("[TB] FAIL lat_done_early i=%0d: got %b expected 0", i, done); end
                if (busy !== 1'b1) begin errors++; $display("[TB] FAIL lat_busy i=%0d: got %b expected 1", i, busy); end
            end
        end
        checks += 4;
        if (done !== 1'b1) begin errors++; $display("[TB] FAIL lat_done_t11: got %b expected 1", done); end
        if (bcd !== 12'h255) begin errors++; $display("[TB] FAIL lat_bcd: got %h expected 255", bcd); end
        if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL lat_ovf: got %b expected 0", ovf); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL lat_busy_idle: got %b expected 0", busy); end
        step();
        checks++;
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL lat_done_pulse: got %b expected 0", done); end
        wait_dig(3'b001, ok);
        checks++;
        if (!ok || seg !== 7'b1011011) begin errors++; $display("[TB] FAIL lat_seg_ones: got %b expected 1011011", seg); end
    endtask

    task automatic test_overflow_1023();
        bit ok;
        logic [2:0] digs [3];
        digs[0] = 3'b001; digs[1] = 3'b010; digs[2] = 3'b100;
        bin = 10'd1023;
        bin_valid = 1'b1;
        step();
        bin_valid = 1'b0;
        wait_done(ok);
        checks += 3;
        if (!ok) begin errors++; $display("[TB] FAIL ovf_done_timeout: got 0 expected 1"); end
        if (bcd !== 12'h999) begin errors++; $display("[TB] FAIL ovf_bcd: got %h expected 999", bcd); end
        if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %b expected 1", ovf); end
        step();
        for (int d = 0; d < 3; d++) begin
            wait_dig(digs[d], ok);
            checks++;
            if (!ok || seg !== 7'b1111011) begin errors++; $display("[TB] FAIL ovf_seg dig=%b: got %b expected 1111011", digs[d], seg); end
        end
    endtask

    task automatic test_lead_blank_7();
        bit ok;
        logic [2:0] digs [3];
        logic [6:0] exp_b [3];
        logic [6:0] exp_nb [3];
        digs[0] = 3'b001;  digs[1] = 3'b010;  digs[2] = 3'b100;
        exp_b[0] = 7'b1110000; exp_b[1] = 7'b0000000; exp_b[2] = 7'b0000000;
        exp_nb[0] = 7'b1110000; exp_nb[1] = 7'b1111110; exp_nb[2] = 7'b1111110;
        bin = 10'd7;
        bin_valid = 1'b1;
        step();
        bin_valid = 1'b0;
        wait_done(ok);
        checks += 3;
        if (!ok) begin errors++; $display("[TB] FAIL lb_done_timeout: got 0 expected 1"); end
        if (bcd !== 12'h007) begin errors++; $display("[TB] FAIL lb_bcd: got %h expected 007", bcd); end
        if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL lb_ovf: got %b expected 0", ovf); end
        step();
        for (int d = 0; d < 3; d++) begin
            wait_dig(digs[d], ok);
            checks += 2;
            if (!ok || seg !== exp_b[d]) begin errors++; $display("[TB] FAIL lb_seg_blank dig=%b: got %b expected %b", digs[d], seg, exp_b[d]); end
            if (!ok || dig_en_nb !== digs[d] || seg_nb !== exp_nb[d]) begin errors++; $display("[TB] FAIL lb_seg_noblank dig=%b: got %b/%b expected %b/%b", digs[d], dig_en_nb, seg_nb, digs[d], exp_nb[d]); end
        end
    endtask

    task automatic test_back_to_back();
        int done_cnt = 0;
        bin = 10'd123;
        bin_valid = 1'b1;
        step();
        bin_valid = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            if (i == 3 || i == 10) begin
                bin = 10'd500;
                bin_valid = 1'b1;
            end else begin
                bin_valid = 1'b0;
            end
            step();
            if (done === 1'b1) done_cnt++;
        end
        bin_valid = 1'b0;
        checks += 3;
        if (done_cnt != 1) begin errors++; $display("[TB] FAIL b2b_done_count: got %0d expected 1", done_cnt); end
        if (bcd !== 12'h123) begin errors++; $display("[TB] FAIL b2b_bcd: got %h expected 123", bcd); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_busy: got %b expected 0", busy); end
    endtask

    task automatic test_reset_abort();
        bit ok;
        int done_cnt = 0;
        bin = 10'd999;
        bin_valid = 1'b1;
        step();
        bin_valid = 1'b0;
        for (int i = 1; i <= 4; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done === 1'b1) done_cnt++;
        end
        checks += 3;
        if (done_cnt != 0) begin errors++; $display("[TB] FAIL abort_done_count: got %0d expected 0", done_cnt); end
        if (bcd !== 12'h000) begin errors++; $display("[TB] FAIL abort_bcd: got %h expected 000", bcd); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
        rst = 1'b1;
        bin = 10'd42;
        bin_valid = 1'b1;
        step();
        rst = 1'b0;
        bin_valid = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_over_valid_busy: got %b expected 0", busy); end
        bin = 10'd42;
        bin_valid = 1'b1;
        step();
        bin_valid = 1'b0;
        wait_done(ok);
        checks += 2;
        if (!ok) begin errors++; $display("[TB] FAIL abort_next_timeout: got 0 expected 1"); end
        if (bcd !== 12'h042) begin errors++; $display("[TB] FAIL abort_next_bcd: got %h expected 042", bcd); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_latency_255();
        test_overflow_1023();
        test_lead_blank_7();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
